hls_kernel_shell: RTL and testbench



---
 rtl/hls_shell_pkg.sv | 22 ++
 rtl/hls_sp_ram.sv | 35 +++
 rtl/hls_kernel_shell.sv | 151 +++++++++++++++
 tb/tb_hls_kernel_shell.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_shell_pkg.sv
// Shared types and helpers for the HLS kernel shell: run-control FSM states,
// counter width and a per-channel slice helper for packed kernel buses.
package hls_shell_pkg;

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_e;

  localparam int CNT_W      = 32;
  localparam int BUS_MAX_W  = 4096;
  localparam int CHAN_MAX_W = 64;

  // Channel idx of a bus packed as w-bit fields, channel 0 in the LSBs.
  function automatic logic [CHAN_MAX_W-1:0] chan_slice(input logic [BUS_MAX_W-1:0] bus,
                                                       input int unsigned idx,
                                                       input int unsigned w);
    logic [BUS_MAX_W-1:0]  sh;
    logic [CHAN_MAX_W-1:0] mask;
    sh   = bus >> (idx * w);
    mask = (w >= CHAN_MAX_W) ? '1 : ((CHAN_MAX_W'(1) << w) - CHAN_MAX_W'(1));
    return sh[CHAN_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/hls_sp_ram.sv
// Single-port RAM, synchronous one-cycle read, write-first. Addresses at or
// beyond DEPTH drop writes and read as zero.
module hls_sp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  assign in_range = 32'(addr) < 32'(DEPTH);
  assign idx      = IDX_W'(addr);

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        if (in_range) mem[idx] <= wdata;
        q <= wdata;
      end else begin
        q <= in_range ? mem[idx] : '0;
      end
    end
  end

endmodule

// File: rtl/hls_kernel_shell.sv
// Run-control and memory shell for an ap_ctrl_hs kernel: owns NUM_MEMS RAMs,
// hands them to the host in IDLE and to the kernel otherwise, times each run.
module hls_kernel_shell
  import hls_shell_pkg::*;
#(
  parameter int          NUM_MEMS = 4,
  parameter int          ADDR_W   = 10,
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 1 << ADDR_W,
  parameter int unsigned TIMEOUT  = 0,
  parameter int          SEL_W    = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         cmd_start,
  output logic                         cmd_busy,
  output logic                         cmd_done,
  output logic                         cmd_timeout,
  output logic [CNT_W-1:0]             cycle_count,
  input  logic                         host_mem_en,
  input  logic                         host_mem_we,
  input  logic [SEL_W-1:0]             host_mem_sel,
  input  logic [ADDR_W-1:0]            host_mem_addr,
  input  logic [DATA_W-1:0]            host_mem_wdata,
  output logic [DATA_W-1:0]            host_mem_rdata,
  output logic                         host_mem_rvalid,
  output logic                         host_mem_err,
  output logic                         k_ap_start,
  input  logic                         k_ap_done,
  input  logic                         k_ap_ready,
  input  logic                         k_ap_idle,
  input  logic [NUM_MEMS-1:0]          k_ce0,
  input  logic [NUM_MEMS-1:0]          k_we0,
  input  logic [NUM_MEMS*ADDR_W-1:0]   k_address0,
  input  logic [NUM_MEMS*DATA_W-1:0]   k_d0,
  output logic [NUM_MEMS*DATA_W-1:0]   k_q0
);

  state_e                             state_q, state_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d, cnt_inc;
  logic                               tmo_q, tmo_d;
  logic                               err_q, err_d, rvld_q, rvld_d;
  logic [SEL_W-1:0]                   hsel_q, hsel_d;
  logic [DATA_W-1:0]                  hhold_q, hhold_d;
  logic [NUM_MEMS-1:0]                krd_q, krd_d;
  logic [NUM_MEMS-1:0][DATA_W-1:0]    ram_q, khold_q, khold_d, kq;
  logic                               host_ok, running;

  assign running = (state_q == START) || (state_q == RUN);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign host_ok = host_mem_en && (state_q == IDLE) && (32'(host_mem_sel) < 32'(NUM_MEMS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE:  if (cmd_start && k_ap_idle) begin
               state_d = START;
               cnt_d   = '0;
               tmo_d   = 1'b0;
             end
      START: begin
               cnt_d = cnt_inc;
               if (k_ap_ready) state_d = k_ap_done ? DONE : RUN;
             end
      RUN:   begin
               cnt_d = cnt_inc;
               if (k_ap_done) state_d = DONE;
             end
      default: state_d = IDLE;
    endcase
    // Timeout is advisory only; the kernel is never aborted.
    if (running && (TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT))) tmo_d = 1'b1;
  end

  always_comb begin
    err_d  = host_mem_en && !host_ok;
    rvld_d = host_ok && !host_mem_we;
    hsel_d = host_ok ? host_mem_sel : hsel_q;
    krd_d  = (state_q != IDLE) ? (k_ce0 & ~k_we0) : '0;
    // Read ports present fresh RAM data only after their own reads; else hold.
    host_mem_rdata = rvld_q ? ram_q[hsel_q] : hhold_q;
    hhold_d        = host_mem_rdata;
    for (int c = 0; c < NUM_MEMS; c++) kq[c] = krd_q[c] ? ram_q[c] : khold_q[c];
    khold_d = kq;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
      rvld_q  <= 1'b0;
      hsel_q  <= '0;
      hhold_q <= '0;
      krd_q   <= '0;
      khold_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      rvld_q  <= rvld_d;
      hsel_q  <= hsel_d;
      hhold_q <= hhold_d;
      krd_q   <= krd_d;
      khold_q <= khold_d;
    end
  end

  for (genvar c = 0; c < NUM_MEMS; c++) begin : g_ch
    logic              r_en, r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    always_comb begin
      if (state_q == IDLE) begin
        r_en    = host_ok && (32'(host_mem_sel) == 32'(c));
        r_we    = host_mem_we;
        r_addr  = host_mem_addr;
        r_wdata = host_mem_wdata;
      end else begin
        r_en    = k_ce0[c];
        r_we    = k_we0[c];
        r_addr  = ADDR_W'(chan_slice(BUS_MAX_W'(k_address0), c, ADDR_W));
        r_wdata = DATA_W'(chan_slice(BUS_MAX_W'(k_d0), c, DATA_W));
      end
    end

    hls_sp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
      .clk   (ap_clk),
      .en    (r_en),
      .we    (r_we),
      .addr  (r_addr),
      .wdata (r_wdata),
      .q     (ram_q[c])
    );
  end

  assign cmd_busy        = (state_q != IDLE);
  assign cmd_done        = (state_q == DONE);
  assign k_ap_start      = (state_q == START);
  assign cmd_timeout     = tmo_q;
  assign cycle_count     = cnt_q;
  assign host_mem_rvalid = rvld_q;
  assign host_mem_err    = err_q;
  assign k_q0            = kq;

endmodule

// File: tb/tb_hls_kernel_shell.sv
// Directed bench for hls_kernel_shell: host load/readback, kernel runs,
// rejection, handshake corner, bounds, timeout and asynchronous reset.
module tb_hls_kernel_shell;
  localparam int NM = 3, AW = 4, DW = 32, DP = 12, TO = 10;

  logic              ap_clk = 1'b0, ap_rst_n;
  logic              cmd_start, cmd_busy, cmd_done, cmd_timeout;
  logic [31:0]       cycle_count;
  logic              host_mem_en, host_mem_we, host_mem_rvalid, host_mem_err;
  logic [1:0]        host_mem_sel;
  logic [AW-1:0]     host_mem_addr;
  logic [DW-1:0]     host_mem_wdata, host_mem_rdata;
  logic              k_ap_start, k_ap_done, k_ap_ready, k_ap_idle;
  logic [NM-1:0]     k_ce0, k_we0;
  logic [NM*AW-1:0]  k_address0;
  logic [NM*DW-1:0]  k_d0, k_q0;

  int checks = 0, failures = 0;

  hls_kernel_shell #(.NUM_MEMS(NM), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DP), .TIMEOUT(TO)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cmd_start(cmd_start), .cmd_busy(cmd_busy),
    .cmd_done(cmd_done), .cmd_timeout(cmd_timeout), .cycle_count(cycle_count),
    .host_mem_en(host_mem_en), .host_mem_we(host_mem_we), .host_mem_sel(host_mem_sel),
    .host_mem_addr(host_mem_addr), .host_mem_wdata(host_mem_wdata),
    .host_mem_rdata(host_mem_rdata), .host_mem_rvalid(host_mem_rvalid),
    .host_mem_err(host_mem_err), .k_ap_start(k_ap_start), .k_ap_done(k_ap_done),
    .k_ap_ready(k_ap_ready), .k_ap_idle(k_ap_idle), .k_ce0(k_ce0), .k_we0(k_we0),
    .k_address0(k_address0), .k_d0(k_d0), .k_q0(k_q0)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic host_write(input logic [1:0] sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_mem_en = 1'b1; host_mem_we = 1'b1; host_mem_sel = sel; host_mem_addr = a; host_mem_wdata = d;
    tick();
    host_mem_en = 1'b0; host_mem_we = 1'b0;
  endtask

  task automatic host_read(input logic [1:0] sel, input logic [AW-1:0] a,
                           output logic rv, output logic [DW-1:0] rd, output logic er);
    host_mem_en = 1'b1; host_mem_we = 1'b0; host_mem_sel = sel; host_mem_addr = a;
    tick();
    rv = host_mem_rvalid; rd = host_mem_rdata; er = host_mem_err;
    host_mem_en = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b1;
    cmd_start = 0; host_mem_en = 0; host_mem_we = 0; host_mem_sel = 0; host_mem_addr = 0;
    host_mem_wdata = 0; k_ap_done = 0; k_ap_ready = 0; k_ap_idle = 1; k_ce0 = 0; k_we0 = 0;
    k_address0 = 0; k_d0 = 0;
    #2 ap_rst_n = 1'b0;
    #20;
    checks++;
    if ({cmd_busy, cmd_done, cmd_timeout, k_ap_start, host_mem_rvalid, host_mem_err} !== 6'b0) begin
      failures++; $display("FAIL reset_flags: got %b want 000000",
        {cmd_busy, cmd_done, cmd_timeout, k_ap_start, host_mem_rvalid, host_mem_err});
    end
    checks++;
    if ({cycle_count, host_mem_rdata, k_q0} !== '0) begin
      failures++; $display("FAIL reset_data: cycle_count=%0d rdata=%h k_q0=%h want 0", cycle_count, host_mem_rdata, k_q0);
    end
    @(posedge ap_clk); #1 ap_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_readback();
    logic rv, er; logic [DW-1:0] rd;
    for (int i = 0; i < 8; i++) host_write(2'd2, AW'(i), 32'hA5A5_0000 + i);
    for (int i = 0; i < 8; i++) begin
      host_read(2'd2, AW'(i), rv, rd, er);
      checks++;
      if ({rv, er} !== 2'b10 || rd !== 32'hA5A5_0000 + i) begin
        failures++; $display("FAIL load_readback[%0d]: rvalid=%b err=%b data=%h want 1 0 %h", i, rv, er, rd, 32'hA5A5_0000 + i);
      end
    end
    tick();
    checks++;
    if (host_mem_rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_pulse: got %b want 0", host_mem_rvalid); end
  endtask

  task automatic test_single_run();
    logic rv, er; logic [DW-1:0] rd;
    cmd_start = 1'b1;
    checks++;
    if (k_ap_start !== 1'b0) begin failures++; $display("FAIL start_early: got %b want 0", k_ap_start); end
    tick();
    cmd_start = 1'b0;
    checks++;
    if ({k_ap_start, cmd_busy} !== 2'b11) begin failures++; $display("FAIL start_rise: got %b want 11", {k_ap_start, cmd_busy}); end
    repeat (2) tick();
    checks++;
    if (k_ap_start !== 1'b1) begin failures++; $display("FAIL start_hold: got %b want 1", k_ap_start); end
    k_ap_ready = 1'b1;
    tick();
    k_ap_ready = 1'b0;
    checks++;
    if (k_ap_start !== 1'b0) begin failures++; $display("FAIL start_drop: got %b want 0", k_ap_start); end
    k_ce0 = 3'b001; k_we0 = 3'b001; k_address0 = 12'h005; k_d0 = {64'h0, 32'hDEAD_0005};
    tick();
    k_we0 = 3'b000;
    tick();
    k_ce0 = 3'b000;
    checks++;
    if (k_q0[31:0] !== 32'hDEAD_0005) begin failures++; $display("FAIL kernel_raw: got %h want dead0005", k_q0[31:0]); end
    repeat (17) tick();
    k_ap_done = 1'b1;
    tick();
    k_ap_done = 1'b0;
    checks++;
    if ({cmd_done, cmd_timeout} !== 2'b11 || cycle_count !== 32'd23) begin
      failures++; $display("FAIL run_done: done=%b timeout=%b count=%0d want 1 1 23", cmd_done, cmd_timeout, cycle_count);
    end
    tick();
    checks++;
    if ({cmd_done, cmd_busy} !== 2'b00 || cycle_count !== 32'd23) begin
      failures++; $display("FAIL run_idle: done=%b busy=%b count=%0d want 0 0 23", cmd_done, cmd_busy, cycle_count);
    end
    host_read(2'd0, 4'd5, rv, rd, er);
    checks++;
    if (rv !== 1'b1 || rd !== 32'hDEAD_0005) begin failures++; $display("FAIL kernel_write_visible: rvalid=%b data=%h want 1 dead0005", rv, rd); end
  endtask

  task automatic test_busy_rejection();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    checks++;
    if (cmd_timeout !== 1'b0) begin failures++; $display("FAIL timeout_clear: got %b want 0", cmd_timeout); end
    k_ap_ready = 1'b1;
    tick();
    k_ap_ready = 1'b0;
    host_mem_en = 1'b1; host_mem_we = 1'b0; host_mem_sel = 2'd1; host_mem_addr = 0; cmd_start = 1'b1;
    tick();
    host_mem_en = 1'b0; cmd_start = 1'b0;
    checks++;
    if ({host_mem_err, host_mem_rvalid} !== 2'b10) begin failures++; $display("FAIL busy_err: err,rvalid=%b want 10", {host_mem_err, host_mem_rvalid}); end
    tick();
    checks++;
    if (host_mem_err !== 1'b0) begin failures++; $display("FAIL busy_err_pulse: got %b want 0", host_mem_err); end
    k_ap_done = 1'b1;
    tick();
    k_ap_done = 1'b0;
    checks++;
    if (cmd_done !== 1'b1) begin failures++; $display("FAIL busy_done: got %b want 1", cmd_done); end
    repeat (2) tick();
    checks++;
    if ({cmd_busy, cmd_done, k_ap_start} !== 3'b000) begin failures++; $display("FAIL no_queue: busy,done,start=%b want 000", {cmd_busy, cmd_done, k_ap_start}); end
  endtask

  task automatic test_same_cycle();
    cmd_start = 1'b1;
    host_mem_en = 1'b1; host_mem_we = 1'b0; host_mem_sel = 2'd2; host_mem_addr = 4'd1;
    tick();
    cmd_start = 1'b0; host_mem_en = 1'b0;
    checks++;
    if ({k_ap_start, host_mem_rvalid} !== 2'b11 || host_mem_rdata !== 32'hA5A5_0001) begin
      failures++; $display("FAIL start_with_read: start,rvalid=%b data=%h want 11 a5a50001", {k_ap_start, host_mem_rvalid}, host_mem_rdata);
    end
    k_ap_ready = 1'b1; k_ap_done = 1'b1;
    tick();
    k_ap_ready = 1'b0; k_ap_done = 1'b0;
    checks++;
    if ({cmd_done, k_ap_start, cmd_busy} !== 3'b101 || cycle_count !== 32'd1) begin
      failures++; $display("FAIL same_cycle: done,start,busy=%b count=%0d want 101 1", {cmd_done, k_ap_start, cmd_busy}, cycle_count);
    end
    tick();
    checks++;
    if (cmd_busy !== 1'b0) begin failures++; $display("FAIL same_cycle_idle: got %b want 0", cmd_busy); end
  endtask

  task automatic test_idle_gate();
    k_ap_idle = 1'b0; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0; k_ap_idle = 1'b1;
    checks++;
    if ({cmd_busy, k_ap_start} !== 2'b00) begin failures++; $display("FAIL idle_gate: busy,start=%b want 00", {cmd_busy, k_ap_start}); end
  endtask

  task automatic test_bounds();
    logic rv, er; logic [DW-1:0] rd;
    host_write(2'd1, 4'd11, 32'h0BAD_000B);
    host_write(2'd1, 4'd12, 32'h1234_5678);
    host_read(2'd1, 4'd11, rv, rd, er);
    checks++;
    if ({rv, er} !== 2'b10 || rd !== 32'h0BAD_000B) begin failures++; $display("FAIL last_word: rv,err=%b data=%h want 10 0bad000b", {rv, er}, rd); end
    host_read(2'd1, 4'd12, rv, rd, er);
    checks++;
    if ({rv, er} !== 2'b10 || rd !== 32'h0) begin failures++; $display("FAIL beyond_depth: rv,err=%b data=%h want 10 0", {rv, er}, rd); end
    host_write(2'd3, 4'd0, 32'hFFFF_FFFF);
    checks++;
    if ({host_mem_err, host_mem_rvalid} !== 2'b10) begin failures++; $display("FAIL bad_sel_write: err,rvalid=%b want 10", {host_mem_err, host_mem_rvalid}); end
    host_read(2'd3, 4'd0, rv, rd, er);
    checks++;
    if ({er, rv} !== 2'b10) begin failures++; $display("FAIL bad_sel_read: err,rvalid=%b want 10", {er, rv}); end
  endtask

  task automatic test_timeout_reset();
    logic rv, er, tmo9; logic [DW-1:0] rd;
    tmo9 = 1'b1;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0; k_ap_ready = 1'b1;
    tick();
    k_ap_ready = 1'b0;
    for (int i = 0; i < 40 && cycle_count != 32'd10; i++) begin
      if (cycle_count == 32'd9) tmo9 = cmd_timeout;
      tick();
    end
    checks++;
    if (cycle_count !== 32'd10) begin failures++; $display("FAIL timeout_reach: count=%0d want 10", cycle_count); end
    checks++;
    if ({tmo9, cmd_timeout} !== 2'b01) begin failures++; $display("FAIL timeout_edge: at9,at10=%b want 01", {tmo9, cmd_timeout}); end
    repeat (5) tick();
    checks++;
    if ({cmd_busy, cmd_timeout, k_ap_start, cmd_done} !== 4'b1100 || cycle_count !== 32'd15) begin
      failures++; $display("FAIL timeout_wait: busy,tmo,start,done=%b count=%0d want 1100 15", {cmd_busy, cmd_timeout, k_ap_start, cmd_done}, cycle_count);
    end
    #2 ap_rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_busy, cmd_timeout, k_ap_start, cmd_done, host_mem_rvalid, host_mem_err} !== 6'b0 || cycle_count !== 32'd0) begin
      failures++; $display("FAIL async_reset: flags=%b count=%0d want 0 0",
        {cmd_busy, cmd_timeout, k_ap_start, cmd_done, host_mem_rvalid, host_mem_err}, cycle_count);
    end
    #2 ap_rst_n = 1'b1;
    tick();
    host_read(2'd2, 4'd3, rv, rd, er);
    checks++;
    if (rv !== 1'b1 || rd !== 32'hA5A5_0003) begin failures++; $display("FAIL ram_survives_c2: rv=%b data=%h want 1 a5a50003", rv, rd); end
    host_read(2'd0, 4'd5, rv, rd, er);
    checks++;
    if (rv !== 1'b1 || rd !== 32'hDEAD_0005) begin failures++; $display("FAIL ram_survives_c0: rv=%b data=%h want 1 dead0005", rv, rd); end
  endtask

  initial begin
    test_reset();
    test_load_readback();
    test_single_run();
    test_busy_rejection();
    test_same_cycle();
    test_idle_gate();
    test_bounds();
    test_timeout_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
